// File: rtl/otter_iobus_timer.sv
// OTTER IOBUS timer: prescaled 32-bit counter with compare match and sticky interrupt.
// Define OTTER_TIMER_MATCHES_EN to add the saturating MATCHES counter at offset 0x14.
module otter_iobus_timer #(
   parameter logic [31:0] BASE_ADDR  = 32'h1100_0200,
   parameter int          PRESCALE_W = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [31:0] RD_DATA,
   output logic        RD_HIT,
   output logic        INT
);

   logic                  in_win;
   logic [2:0]            offs;
   logic                  wr_hit;
   logic                  wr_ctrl, wr_pre, wr_cmp, wr_cnt, wr_sts;
   logic                  ctrl_en, ctrl_ar, ctrl_ie;
   logic [PRESCALE_W-1:0] prescale;
   logic [PRESCALE_W-1:0] ps;
   logic [31:0]           compare;
   logic [31:0]           count;
   logic                  pend;
   logic                  tick;
   logic                  cmp_eq;
   logic                  match;
   logic                  en_rise;
   logic [31:0]           rd_mux;
   logic                  unused_addr;

   assign in_win      = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
   assign offs        = IOBUS_ADDR[4:2];
   assign unused_addr = ^IOBUS_ADDR[1:0];
   assign wr_hit      = IOBUS_WR & in_win;

   assign wr_ctrl = wr_hit & (offs == 3'd0);
   assign wr_pre  = wr_hit & (offs == 3'd1);
   assign wr_cmp  = wr_hit & (offs == 3'd2);
   assign wr_cnt  = wr_hit & (offs == 3'd3);
   assign wr_sts  = wr_hit & (offs == 3'd4);

   assign tick    = ctrl_en & (ps == prescale);
   assign cmp_eq  = (count == compare);
   // A software COUNT write suppresses both the increment and the match check
   assign match   = tick & ~wr_cnt & cmp_eq;
   assign en_rise = wr_ctrl & IOBUS_OUT[0] & ~ctrl_en;

   assign INT = pend & ctrl_ie;

`ifdef OTTER_TIMER_MATCHES_EN
   logic       wr_mat;
   logic [7:0] matches;

   assign wr_mat = wr_hit & (offs == 3'd5);

   always_ff @(posedge CLK) begin
      if (RST) begin
         matches <= 8'd0;
      end else if (wr_mat) begin
         matches <= 8'd0;
      end else if (match && matches != 8'hFF) begin
         matches <= matches + 8'd1;
      end
   end
`endif

   always_comb begin
      rd_mux = 32'd0;
      case (offs)
         3'd0:    rd_mux = {29'd0, ctrl_ie, ctrl_ar, ctrl_en};
         3'd1:    rd_mux = 32'(prescale);
         3'd2:    rd_mux = compare;
         3'd3:    rd_mux = count;
         3'd4:    rd_mux = {31'd0, pend};
`ifdef OTTER_TIMER_MATCHES_EN
         3'd5:    rd_mux = {24'd0, matches};
`endif
         default: rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ctrl_en  <= 1'b0;
         ctrl_ar  <= 1'b0;
         ctrl_ie  <= 1'b0;
         prescale <= '0;
         ps       <= '0;
         compare  <= 32'hFFFF_FFFF;
         count    <= 32'd0;
         pend     <= 1'b0;
         RD_DATA  <= 32'd0;
         RD_HIT   <= 1'b0;
      end else begin
         if (en_rise) begin
            ps <= '0;
         end else if (ctrl_en) begin
            ps <= tick ? '0 : ps + PRESCALE_W'(1);
         end

         // Written EN wins over the one-shot auto-disable
         if (wr_ctrl) begin
            {ctrl_ie, ctrl_ar, ctrl_en} <= IOBUS_OUT[2:0];
         end else if (match && !ctrl_ar) begin
            ctrl_en <= 1'b0;
         end

         if (wr_pre) prescale <= IOBUS_OUT[PRESCALE_W-1:0];
         if (wr_cmp) compare  <= IOBUS_OUT;

         if (wr_cnt) begin
            count <= IOBUS_OUT;
         end else if (tick) begin
            if (!cmp_eq) begin
               count <= count + 32'd1;
            end else if (ctrl_ar) begin
               count <= 32'd0;
            end
         end

         if (match) begin
            pend <= 1'b1;
         end else if (wr_sts && IOBUS_OUT[0]) begin
            pend <= 1'b0;
         end

         RD_HIT  <= in_win;
         RD_DATA <= in_win ? rd_mux : 32'd0;
      end
   end

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Scoreboard bench for otter_iobus_timer: expected reads queued at issue, checked one cycle later.
// MATCHES checks follow OTTER_TIMER_MATCHES_EN.
module tb_otter_iobus_timer;

   localparam logic [31:0] BASE  = 32'h1100_0200;
   localparam logic [7:0]  O_CTL = 8'h00;
   localparam logic [7:0]  O_PRE = 8'h04;
   localparam logic [7:0]  O_CMP = 8'h08;
   localparam logic [7:0]  O_CNT = 8'h0C;
   localparam logic [7:0]  O_STS = 8'h10;
   localparam logic [7:0]  O_MAT = 8'h14;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] IOBUS_ADDR = 32'd0;
   logic [31:0] IOBUS_OUT = 32'd0;
   logic        IOBUS_WR = 1'b0;
   logic [31:0] RD_DATA;
   logic        RD_HIT;
   logic        INT;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [32:0] exp_q[$];
   logic [32:0] chk;

   otter_iobus_timer #(
      .BASE_ADDR (BASE),
      .PRESCALE_W(16)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IOBUS_ADDR(IOBUS_ADDR),
      .IOBUS_OUT (IOBUS_OUT),
      .IOBUS_WR  (IOBUS_WR),
      .RD_DATA   (RD_DATA),
      .RD_HIT    (RD_HIT),
      .INT       (INT)
   );

   always #5 CLK = ~CLK;

   task automatic do_reset();
      RST = 1'b1;
      IOBUS_WR = 1'b0;
      IOBUS_ADDR = 32'd0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   task automatic bus_wr(input logic [7:0] off, input logic [31:0] d);
      IOBUS_ADDR = BASE + 32'(off);
      IOBUS_OUT = d;
      IOBUS_WR = 1'b1;
      @(posedge CLK);
      #1;
      IOBUS_WR = 1'b0;
      IOBUS_ADDR = 32'd0;
      IOBUS_OUT = 32'd0;
   endtask

   task automatic bus_rd(input logic [31:0] addr, input logic [32:0] e);
      IOBUS_ADDR = addr;
      IOBUS_WR = 1'b0;
      exp_q.push_back(e);
      @(posedge CLK);
      #1;
      IOBUS_ADDR = 32'd0;
   endtask

   task automatic test_reset();
      logic [31:0] a[5];
      logic [32:0] e[5];
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      n_cmp++;
      if ({RD_HIT, RD_DATA, INT} !== 34'd0) begin
         n_bad++;
         $display("FAIL reset_out: got %h need 0", {RD_HIT, RD_DATA, INT});
      end
      bus_wr(O_CMP, 32'h55);
      bus_wr(O_CNT, 32'h55);
      bus_wr(O_CTL, 32'd7);
      @(posedge CLK);
      #1;
      n_cmp++;
      if (INT !== 1'b1) begin
         n_bad++;
         $display("FAIL pre_reset_int: got %b need 1", INT);
      end
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      n_cmp++;
      if ({RD_HIT, RD_DATA, INT} !== 34'd0) begin
         n_bad++;
         $display("FAIL reset_mid_out: got %h need 0", {RD_HIT, RD_DATA, INT});
      end
      a = '{BASE + 32'h0C, BASE + 32'h08, BASE, BASE + 32'h10, BASE + 32'h04};
      e = '{{1'b1, 32'd0}, {1'b1, 32'hFFFF_FFFF}, {1'b1, 32'd0},
            {1'b1, 32'd0}, {1'b1, 32'd0}};
      for (int i = 0; i < 5; i++) begin
         bus_rd(a[i], e[i]);
         chk = exp_q.pop_front();
         n_cmp++;
         if ({RD_HIT, RD_DATA} !== chk) begin
            n_bad++;
            $display("FAIL reset_rd[%0d]: got %h need %h", i, {RD_HIT, RD_DATA}, chk);
         end
      end
   endtask

   task automatic test_auto_reload();
      do_reset();
      bus_wr(O_PRE, 32'd3);
      bus_wr(O_CMP, 32'd2);
      bus_wr(O_CTL, 32'd7);
      for (int k = 0; k < 16; k++) begin
         bus_rd(BASE + 32'h0C, {1'b1, 32'((k / 4) % 3)});
         chk = exp_q.pop_front();
         n_cmp++;
         if ({RD_HIT, RD_DATA} !== chk) begin
            n_bad++;
            $display("FAIL ar_count[%0d]: got %h need %h", k, {RD_HIT, RD_DATA}, chk);
         end
         n_cmp++;
         if (INT !== logic'(k >= 11)) begin
            n_bad++;
            $display("FAIL ar_int[%0d]: got %b need %b", k, INT, k >= 11);
         end
      end
      bus_wr(O_STS, 32'd1);
      n_cmp++;
      if (INT !== 1'b0) begin
         n_bad++;
         $display("FAIL ar_int_clear: got %b need 0", INT);
      end
      bus_rd(BASE + 32'h10, {1'b1, 32'd0});
      chk = exp_q.pop_front();
      n_cmp++;
      if ({RD_HIT, RD_DATA} !== chk) begin
         n_bad++;
         $display("FAIL ar_status: got %h need %h", {RD_HIT, RD_DATA}, chk);
      end
      bus_wr(O_CTL, 32'd0);
   endtask

   task automatic test_one_shot();
      logic [31:0] a[4];
      logic [32:0] e[4];
      do_reset();
      bus_wr(O_CMP, 32'd5);
      bus_wr(O_CTL, 32'b101);
      repeat (20) @(posedge CLK);
      #1;
      n_cmp++;
      if (INT !== 1'b1) begin
         n_bad++;
         $display("FAIL os_int: got %b need 1", INT);
      end
      a = '{BASE + 32'h0C, BASE, BASE + 32'h10, BASE + 32'h0C};
      e = '{{1'b1, 32'd5}, {1'b1, 32'd4}, {1'b1, 32'd1}, {1'b1, 32'd5}};
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            repeat (20) @(posedge CLK);
            #1;
         end
         bus_rd(a[i], e[i]);
         chk = exp_q.pop_front();
         n_cmp++;
         if ({RD_HIT, RD_DATA} !== chk) begin
            n_bad++;
            $display("FAIL os_rd[%0d]: got %h need %h", i, {RD_HIT, RD_DATA}, chk);
         end
      end
   endtask

   task automatic test_collisions();
      do_reset();
      bus_wr(O_CMP, 32'd3);
      bus_wr(O_CTL, 32'b101);
      repeat (3) @(posedge CLK);
      #1;
      bus_wr(O_STS, 32'd1);
      n_cmp++;
      if (INT !== 1'b1) begin
         n_bad++;
         $display("FAIL col_clr_int: got %b need 1", INT);
      end
      bus_rd(BASE + 32'h10, {1'b1, 32'd1});
      chk = exp_q.pop_front();
      n_cmp++;
      if ({RD_HIT, RD_DATA} !== chk) begin
         n_bad++;
         $display("FAIL col_clr_pend: got %h need %h", {RD_HIT, RD_DATA}, chk);
      end

      do_reset();
      bus_wr(O_PRE, 32'd3);
      bus_wr(O_CTL, 32'd1);
      repeat (3) @(posedge CLK);
      #1;
      bus_wr(O_CNT, 32'h10);
      bus_wr(O_CTL, 32'd0);
      bus_rd(BASE + 32'h0C, {1'b1, 32'h10});
      chk = exp_q.pop_front();
      n_cmp++;
      if ({RD_HIT, RD_DATA} !== chk) begin
         n_bad++;
         $display("FAIL col_cnt_wr: got %h need %h", {RD_HIT, RD_DATA}, chk);
      end

      do_reset();
      bus_wr(O_CMP, 32'd2);
      bus_wr(O_CTL, 32'd1);
      repeat (2) @(posedge CLK);
      #1;
      bus_wr(O_CTL, 32'd1);
      bus_rd(BASE, {1'b1, 32'd1});
      chk = exp_q.pop_front();
      n_cmp++;
      if ({RD_HIT, RD_DATA} !== chk) begin
         n_bad++;
         $display("FAIL col_ctrl_en: got %h need %h", {RD_HIT, RD_DATA}, chk);
      end
   endtask

   task automatic test_read_decode();
      logic [31:0] a[7];
      logic [32:0] e[7];
      do_reset();
      bus_wr(O_CMP, 32'hA5A5_1234);
      bus_wr(O_PRE, 32'h0001_2345);
      a = '{BASE + 32'h08, BASE + 32'h0B, BASE + 32'h40, BASE + 32'h18,
            BASE + 32'h04, BASE + 32'h1C, BASE - 32'h04};
      e = '{{1'b1, 32'hA5A5_1234}, {1'b1, 32'hA5A5_1234}, {1'b0, 32'd0},
            {1'b1, 32'd0}, {1'b1, 32'h2345}, {1'b1, 32'd0}, {1'b0, 32'd0}};
      for (int i = 0; i < 7; i++) begin
         bus_rd(a[i], e[i]);
         chk = exp_q.pop_front();
         n_cmp++;
         if ({RD_HIT, RD_DATA} !== chk) begin
            n_bad++;
            $display("FAIL dec_rd[%0d]: got %h need %h", i, {RD_HIT, RD_DATA}, chk);
         end
      end
      IOBUS_ADDR = BASE + 32'h08;
      IOBUS_OUT = 32'h0BAD_F00D;
      IOBUS_WR = 1'b1;
      exp_q.push_back({1'b1, 32'hA5A5_1234});
      @(posedge CLK);
      #1;
      IOBUS_WR = 1'b0;
      IOBUS_ADDR = 32'd0;
      chk = exp_q.pop_front();
      n_cmp++;
      if ({RD_HIT, RD_DATA} !== chk) begin
         n_bad++;
         $display("FAIL dec_rd_before_wr: got %h need %h", {RD_HIT, RD_DATA}, chk);
      end
      bus_rd(BASE + 32'h08, {1'b1, 32'h0BAD_F00D});
      chk = exp_q.pop_front();
      n_cmp++;
      if ({RD_HIT, RD_DATA} !== chk) begin
         n_bad++;
         $display("FAIL dec_rd_after_wr: got %h need %h", {RD_HIT, RD_DATA}, chk);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] a[2];
      logic [32:0] e[2];
      do_reset();
      bus_wr(O_CMP, 32'h10);
      bus_wr(O_CNT, 32'hFFFF_FFFF);
      bus_wr(O_CTL, 32'b101);
      bus_wr(O_CTL, 32'd0);
      a = '{BASE + 32'h0C, BASE + 32'h10};
      e = '{{1'b1, 32'd0}, {1'b1, 32'd0}};
      for (int i = 0; i < 2; i++) begin
         bus_rd(a[i], e[i]);
         chk = exp_q.pop_front();
         n_cmp++;
         if ({RD_HIT, RD_DATA} !== chk) begin
            n_bad++;
            $display("FAIL wrap_rd[%0d]: got %h need %h", i, {RD_HIT, RD_DATA}, chk);
         end
      end
      n_cmp++;
      if (INT !== 1'b0) begin
         n_bad++;
         $display("FAIL wrap_int: got %b need 0", INT);
      end
   endtask

   task automatic test_matches();
      do_reset();
`ifdef OTTER_TIMER_MATCHES_EN
      bus_wr(O_CMP, 32'd0);
      bus_wr(O_CTL, 32'b011);
      for (int k = 0; k < 4; k++) begin
         bus_rd(BASE + 32'h14, {1'b1, 32'(k)});
         chk = exp_q.pop_front();
         n_cmp++;
         if ({RD_HIT, RD_DATA} !== chk) begin
            n_bad++;
            $display("FAIL mat_step[%0d]: got %h need %h", k, {RD_HIT, RD_DATA}, chk);
         end
      end
      repeat (300) @(posedge CLK);
      #1;
      bus_wr(O_CTL, 32'd0);
      n_cmp++;
      if (INT !== 1'b0) begin
         n_bad++;
         $display("FAIL mat_int_ie0: got %b need 0", INT);
      end
      bus_rd(BASE + 32'h14, {1'b1, 32'hFF});
      chk = exp_q.pop_front();
      n_cmp++;
      if ({RD_HIT, RD_DATA} !== chk) begin
         n_bad++;
         $display("FAIL mat_sat: got %h need %h", {RD_HIT, RD_DATA}, chk);
      end
      bus_wr(O_MAT, 32'h1234);
      bus_rd(BASE + 32'h14, {1'b1, 32'd0});
      chk = exp_q.pop_front();
      n_cmp++;
      if ({RD_HIT, RD_DATA} !== chk) begin
         n_bad++;
         $display("FAIL mat_clear: got %h need %h", {RD_HIT, RD_DATA}, chk);
      end
`else
      bus_wr(O_MAT, 32'hFFFF_FFFF);
      bus_rd(BASE + 32'h14, {1'b1, 32'd0});
      chk = exp_q.pop_front();
      n_cmp++;
      if ({RD_HIT, RD_DATA} !== chk) begin
         n_bad++;
         $display("FAIL mat_absent: got %h need %h", {RD_HIT, RD_DATA}, chk);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_auto_reload();
      test_one_shot();
      test_collisions();
      test_read_decode();
      test_wrap();
      test_matches();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
